block_draw_scheduler: RTL and testbench

Shares the single VGA pixel-write port (x, y, colour, plot into `vga_adapter`) among several requesters, such as snake-head draw, tail erase and apple draw. Each request asks for one DIM×DIM square at a given origin and colour. The block arbitrates round-robin, latches the winning request, and rasterises the square at one pixel per clock. It reports per-requester grant and done pulses. It sits between the game FSM and `vga_adapter`, replacing ad-hoc XC/YC counter sequencing in the top level.

---
 rtl/snake_draw_pkg.sv | 21 ++
 rtl/block_draw_scheduler_if.sv | 31 +++
 rtl/UpDn_count.sv | 28 ++
 rtl/block_draw_scheduler_rr_arbiter.sv | 27 ++
 rtl/block_draw_scheduler.sv | 127 ++++++++++++
 tb/tb_block_draw_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/snake_draw_pkg.sv
// Shared definitions for the block draw path: scheduler state encoding,
// visible screen limits and the default block size.
package snake_draw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int XMAX = 159;
    localparam int YMAX = 119;
    localparam int DIM  = 10;

    // Width of an index able to address n items (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/block_draw_scheduler_if.sv
// Request/grant bus between game-side requesters and the block draw
// scheduler, plus the pixel-write port it drives into vga_adapter.
interface block_draw_scheduler_if #(
    parameter int NREQ = 3,
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int CW   = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ*YW-1:0] req_y;
    logic [NREQ*CW-1:0] req_colour;
    logic               stall;
    logic [NREQ-1:0]    grant;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [XW-1:0]      VGA_X;
    logic [YW-1:0]      VGA_Y;
    logic [CW-1:0]      VGA_COLOR;
    logic               plot;

    modport master (
        output req, req_x, req_y, req_colour, stall,
        input  grant, done, busy, VGA_X, VGA_Y, VGA_COLOR, plot
    );

    modport slave (
        input  req, req_x, req_y, req_colour, stall,
        output grant, done, busy, VGA_X, VGA_Y, VGA_COLOR, plot
    );
endinterface

// File: rtl/UpDn_count.sv
// Generic up/down counter with synchronous active-low reset, synchronous
// load (priority) and count enable.
module UpDn_count #(
    parameter int N = 4
) (
    input  logic         CLOCK_50,
    input  logic         Resetn,
    input  logic         i_load,
    input  logic         i_enable,
    input  logic         i_up,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);
    logic [N-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn)
            r_q <= '0;
        else if (i_load)
            r_q <= i_d;
        else if (i_enable)
            r_q <= i_up ? r_q + N'(1) : r_q - N'(1);
    end

    assign o_q = r_q;
endmodule

// File: rtl/block_draw_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request bit starting just
// above the previous winner, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);
    // NOTE: every output gets a default before the search loop so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        logic [IW-1:0] w_cand;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IW'((int'(i_last) + k) % NREQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end
endmodule

// File: rtl/block_draw_scheduler.sv
// Arbitrates DIM x DIM square draw requests round-robin and rasterises the
// winner onto the single VGA pixel-write port at one pixel per clock.
module block_draw_scheduler #(
    parameter int NREQ = 3,
    parameter int DIM  = snake_draw_pkg::DIM,
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int CW   = 3,
    parameter int XMAX = snake_draw_pkg::XMAX,
    parameter int YMAX = snake_draw_pkg::YMAX
) (
    input  logic                   CLOCK_50,
    input  logic                   Resetn,
    block_draw_scheduler_if.slave  bus
);
    import snake_draw_pkg::*;

    localparam int IW   = idx_width(NREQ);
    localparam int CNTW = idx_width(DIM);

    state_t        r_state;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_idx;
    logic [XW-1:0] r_ox;
    logic [YW-1:0] r_oy;
    logic [CW-1:0] r_colour;

    logic [IW-1:0]   w_idx;
    logic            w_valid;
    logic [CNTW-1:0] w_xc;
    logic [CNTW-1:0] w_yc;
    logic            w_clr;
    logic            w_step;
    logic            w_x_end;
    logic            w_y_end;
    logic [XW:0]     w_sum_x;
    logic [YW:0]     w_sum_y;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .i_req   (bus.req),
        .i_last  (r_last),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_clr   = (r_state == GRANT);
    assign w_step  = (r_state == DRAW) && !bus.stall;
    assign w_x_end = (w_xc == CNTW'(DIM - 1));
    assign w_y_end = (w_yc == CNTW'(DIM - 1));

    // XC wraps and bumps YC on the same edge, so rows change without a gap.
    UpDn_count #(.N(CNTW)) u_xc (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .i_load   (w_clr || (w_step && w_x_end)),
        .i_enable (w_step),
        .i_up     (1'b1),
        .i_d      ('0),
        .o_q      (w_xc)
    );

    UpDn_count #(.N(CNTW)) u_yc (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .i_load   (w_clr),
        .i_enable (w_step && w_x_end),
        .i_up     (1'b1),
        .i_d      ('0),
        .o_q      (w_yc)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            r_state  <= IDLE;
            r_last   <= IW'(NREQ - 1);
            r_idx    <= '0;
            r_ox     <= '0;
            r_oy     <= '0;
            r_colour <= '0;
        end else begin
            case (r_state)
                IDLE:  if (|bus.req) r_state <= GRANT;
                GRANT: begin
                    // A request withdrawn before GRANT is dropped silently.
                    if (w_valid) begin
                        r_state  <= DRAW;
                        r_last   <= w_idx;
                        r_idx    <= w_idx;
                        r_ox     <= bus.req_x[w_idx*XW +: XW];
                        r_oy     <= bus.req_y[w_idx*YW +: YW];
                        r_colour <= bus.req_colour[w_idx*CW +: CW];
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                DRAW:  if (w_step && w_x_end && w_y_end) r_state <= DONE;
                DONE:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_sum_x = {1'b0, r_ox} + (XW+1)'(w_xc);
    assign w_sum_y = {1'b0, r_oy} + (YW+1)'(w_yc);

    always_comb begin
        bus.grant     = '0;
        bus.done      = '0;
        bus.busy      = (r_state != IDLE);
        bus.VGA_X     = '0;
        bus.VGA_Y     = '0;
        bus.VGA_COLOR = '0;
        bus.plot      = 1'b0;
        if (r_state == GRANT && w_valid)
            bus.grant = NREQ'(1) << w_idx;
        if (r_state == DONE)
            bus.done = NREQ'(1) << r_idx;
        if (r_state == DRAW) begin
            bus.VGA_X     = w_sum_x[XW-1:0];
            bus.VGA_Y     = w_sum_y[YW-1:0];
            bus.VGA_COLOR = r_colour;
            // Off-screen pixels still take their cycle but are not written.
            bus.plot      = w_step && (w_sum_x <= (XW+1)'(XMAX))
                                   && (w_sum_y <= (YW+1)'(YMAX));
        end
    end
endmodule

// File: tb/tb_block_draw_scheduler.sv
// Directed self-checking bench for block_draw_scheduler: reset, single draw,
// round-robin order, clipping, stall, reset mid-draw and withdrawn request.
`timescale 1ns/1ps
module tb_block_draw_scheduler;
    localparam int NREQ = 3;
    localparam int XW   = 8;
    localparam int YW   = 7;
    localparam int CW   = 3;

    logic CLOCK_50 = 1'b0;
    logic Resetn   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    block_draw_scheduler_if #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW)) bus ();

    block_draw_scheduler #(
        .NREQ(NREQ), .DIM(10), .XW(XW), .YW(YW), .CW(CW), .XMAX(159), .YMAX(119)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .bus      (bus)
    );

    task automatic apply_reset();
        @(posedge CLOCK_50); #1;
        Resetn = 1'b0; bus.req = '0; bus.stall = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1 Resetn = 1'b1;
    endtask

    task automatic load_req(input int i, input int x, input int y, input int c);
        bus.req_x[i*XW +: XW]      = XW'(x);
        bus.req_y[i*YW +: YW]      = YW'(y);
        bus.req_colour[i*CW +: CW] = CW'(c);
        bus.req = bus.req | (NREQ'(1) << i);
    endtask

    task automatic test_reset();
        @(posedge CLOCK_50); #1;
        Resetn = 1'b0; bus.stall = 1'b1;
        load_req(0, 5, 5, 1); load_req(1, 6, 6, 2); load_req(2, 7, 7, 3);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        checks++;
        if ({bus.grant, bus.done, bus.busy, bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR} !== '0) begin
            failures++;
            $display("FAIL reset_hold: got grant=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%0d, want all 0",
                     bus.grant, bus.done, bus.busy, bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR);
        end
        @(posedge CLOCK_50); #1;
        Resetn = 1'b1; bus.req = '0; bus.stall = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if ({bus.grant, bus.done, bus.busy, bus.plot} !== '0) begin
            failures++;
            $display("FAIL reset_release: got grant=%b done=%b busy=%b plot=%b, want all 0",
                     bus.grant, bus.done, bus.busy, bus.plot);
        end
    endtask

    task automatic test_single();
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        apply_reset();
        @(posedge CLOCK_50); #1;
        load_req(0, 30, 30, 3'b100);
        @(negedge CLOCK_50);
        checks++;
        if (bus.grant !== 3'b000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got grant=%b busy=%b, want grant=000 busy=0", bus.grant, bus.busy);
        end
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.grant !== 3'b001 || bus.busy !== 1'b1 || bus.plot !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: got grant=%b busy=%b plot=%b, want grant=001 busy=1 plot=0",
                     bus.grant, bus.busy, bus.plot);
        end
        for (int p = 0; p < 100; p++) begin
            @(posedge CLOCK_50); #1;
            bus.req = '0;
            @(negedge CLOCK_50);
            ex = XW'(30 + p % 10);
            ey = YW'(30 + p / 10);
            checks++;
            if ({bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, bus.done} !== {1'b1, ex, ey, 3'b100, 3'b000}) begin
                failures++;
                $display("FAIL single_pixel[%0d]: got plot=%b x=%0d y=%0d c=%b done=%b, want plot=1 x=%0d y=%0d c=100 done=000",
                         p, bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, bus.done, ex, ey);
            end
        end
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.done !== 3'b001 || bus.plot !== 1'b0 || bus.VGA_X !== '0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_done: got done=%b plot=%b x=%0d busy=%b, want done=001 plot=0 x=0 busy=1",
                     bus.done, bus.plot, bus.VGA_X, bus.busy);
        end
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 3'b000) begin
            failures++;
            $display("FAIL single_idle_after: got busy=%b done=%b, want busy=0 done=000", bus.busy, bus.done);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] drop;
        logic [NREQ-1:0] g_val [4];
        logic [NREQ-1:0] exp_g [4];
        int              g_cyc [4];
        int              n;
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        apply_reset();
        load_req(0, 0, 0, 1); load_req(1, 20, 0, 2); load_req(2, 40, 0, 3);
        bus.req = '0;
        drop = '0;
        n = 0;
        for (int cyc = 0; cyc < 450 && n < 4; cyc++) begin
            @(posedge CLOCK_50); #1;
            bus.req = 3'b111 & ~drop;
            @(negedge CLOCK_50);
            drop = bus.grant;
            if (bus.grant !== 3'b000) begin
                g_val[n] = bus.grant;
                g_cyc[n] = cyc;
                n++;
            end
        end
        @(posedge CLOCK_50); #1;
        bus.req = '0;
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL rr_grant_count: got %0d grants, want 4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (g_val[i] !== exp_g[i]) begin
                failures++;
                $display("FAIL rr_order[%0d]: got grant=%b, want %b", i, g_val[i], exp_g[i]);
            end
            if (i > 0) begin
                checks++;
                if (g_cyc[i] - g_cyc[i-1] !== 103) begin
                    failures++;
                    $display("FAIL rr_period[%0d]: got %0d cycles, want 103", i, g_cyc[i] - g_cyc[i-1]);
                end
            end
        end
        for (int k = 0; k < 120 && bus.busy; k++) @(negedge CLOCK_50);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_drain: got busy=%b after 120 cycles, want 0", bus.busy);
        end
    endtask

    task automatic test_clipping();
        int   ex, ey, plots, bad;
        logic exp_plot;
        apply_reset();
        @(posedge CLOCK_50); #1;
        load_req(0, 155, 115, 3'b011);
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.grant !== 3'b001) begin
            failures++;
            $display("FAIL clip_grant: got grant=%b, want 001", bus.grant);
        end
        plots = 0;
        bad   = 0;
        for (int p = 0; p < 100; p++) begin
            @(posedge CLOCK_50); #1;
            bus.req = '0;
            @(negedge CLOCK_50);
            ex = 155 + p % 10;
            ey = 115 + p / 10;
            exp_plot = (ex <= 159) && (ey <= 119);
            if (bus.plot === 1'b1) plots++;
            if (bus.plot === 1'b1 && (bus.VGA_X > 8'd159 || bus.VGA_Y > 7'd119)) bad++;
            checks++;
            if ({bus.plot, bus.VGA_X, bus.VGA_Y, bus.done} !== {exp_plot, XW'(ex), YW'(ey), 3'b000}) begin
                failures++;
                $display("FAIL clip_pixel[%0d]: got plot=%b x=%0d y=%0d done=%b, want plot=%b x=%0d y=%0d done=000",
                         p, bus.plot, bus.VGA_X, bus.VGA_Y, bus.done, exp_plot, ex, ey);
            end
        end
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.done !== 3'b001) begin
            failures++;
            $display("FAIL clip_done: got done=%b, want 001", bus.done);
        end
        checks++;
        if (plots !== 25 || bad !== 0) begin
            failures++;
            $display("FAIL clip_count: got plots=%0d offscreen=%0d, want plots=25 offscreen=0", plots, bad);
        end
    endtask

    task automatic test_stall();
        int   p;
        logic exp_plot;
        apply_reset();
        @(posedge CLOCK_50); #1;
        load_req(1, 10, 20, 3'b010);
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.grant !== 3'b010) begin
            failures++;
            $display("FAIL stall_grant: got grant=%b, want 010", bus.grant);
        end
        for (int k = 0; k < 105; k++) begin
            @(posedge CLOCK_50); #1;
            bus.req   = '0;
            bus.stall = (k >= 11 && k < 16);
            @(negedge CLOCK_50);
            p = (k < 11) ? k : ((k < 16) ? 11 : k - 5);
            exp_plot = !(k >= 11 && k < 16);
            checks++;
            if ({bus.plot, bus.VGA_X, bus.VGA_Y, bus.done} !==
                {exp_plot, XW'(10 + p % 10), YW'(20 + p / 10), 3'b000}) begin
                failures++;
                $display("FAIL stall_cycle[%0d]: got plot=%b x=%0d y=%0d done=%b, want plot=%b x=%0d y=%0d done=000",
                         k, bus.plot, bus.VGA_X, bus.VGA_Y, bus.done, exp_plot, 10 + p % 10, 20 + p / 10);
            end
        end
        // Stall raised in the DONE cycle must not hold the pulse.
        @(posedge CLOCK_50); #1;
        bus.stall = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.done !== 3'b010 || bus.plot !== 1'b0) begin
            failures++;
            $display("FAIL stall_done: got done=%b plot=%b, want done=010 plot=0", bus.done, bus.plot);
        end
        @(posedge CLOCK_50); #1;
        bus.stall = 1'b0;
        @(negedge CLOCK_50);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 3'b000) begin
            failures++;
            $display("FAIL stall_idle: got busy=%b done=%b, want busy=0 done=000", bus.busy, bus.done);
        end
    endtask

    task automatic test_reset_mid_draw();
        int stray;
        apply_reset();
        @(posedge CLOCK_50); #1;
        load_req(1, 40, 40, 3'b111);
        @(posedge CLOCK_50); #1;
        for (int k = 0; k < 50; k++) begin
            @(posedge CLOCK_50); #1;
            bus.req = '0;
        end
        @(posedge CLOCK_50); #1;
        Resetn = 1'b0;
        @(posedge CLOCK_50); #1;
        Resetn = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if ({bus.grant, bus.done, bus.busy, bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got grant=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%0d, want all 0",
                     bus.grant, bus.done, bus.busy, bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR);
        end
        stray = 0;
        for (int k = 0; k < 110; k++) begin
            @(negedge CLOCK_50);
            if (bus.done !== 3'b000 || bus.plot !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL midreset_quiet: got %0d cycles with done/plot/busy, want 0", stray);
        end
        @(posedge CLOCK_50); #1;
        load_req(2, 0, 0, 3'b001);
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.grant !== 3'b100) begin
            failures++;
            $display("FAIL midreset_regrant: got grant=%b, want 100", bus.grant);
        end
        @(posedge CLOCK_50); #1;
        bus.req = '0;
    endtask

    task automatic test_withdraw();
        apply_reset();
        @(posedge CLOCK_50); #1;
        load_req(1, 50, 50, 3'b101);
        @(negedge CLOCK_50);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_idle: got busy=%b, want 0", bus.busy);
        end
        @(posedge CLOCK_50); #1;
        bus.req = '0;
        @(negedge CLOCK_50);
        checks++;
        if (bus.grant !== 3'b000 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL withdraw_grant_cycle: got grant=%b busy=%b, want grant=000 busy=1", bus.grant, bus.busy);
        end
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.busy !== 1'b0 || bus.grant !== 3'b000 || bus.plot !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_return: got busy=%b grant=%b plot=%b, want busy=0 grant=000 plot=0",
                     bus.busy, bus.grant, bus.plot);
        end
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_stays_idle: got busy=%b, want 0", bus.busy);
        end
    endtask

    initial begin
        bus.req        = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        bus.stall      = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_clipping();
        test_stall();
        test_reset_mid_draw();
        test_withdraw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
